// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared line types and round-robin pick helper for the icache refill path
package icache_pkg;

  localparam int DEF_LINE_WIDTH      = 64;
  localparam int DEF_LINE_ADDR_WIDTH = 12;
  localparam int MAX_PORTS           = 32;

  typedef logic [DEF_LINE_WIDTH-1:0]      line_t;
  typedef logic [DEF_LINE_ADDR_WIDTH-1:0] line_addr_t;

  // First set bit of mask scanning upward from ptr+1 with wrap at n; -1 if none.
  function automatic int rr_next(input logic [MAX_PORTS-1:0] mask, input int ptr, input int n);
    int idx;
    int pick;
    pick = -1;
    for (int k = 1; k <= MAX_PORTS; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && pick < 0 && mask[idx[4:0]]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant and last-winner pointer
module rr_arbiter
  import icache_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int PORT_ID_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PORTS-1:0]     req,
  input  logic                     enable,
  input  logic                     advance,
  output logic [NUM_PORTS-1:0]     grant,
  output logic [PORT_ID_WIDTH-1:0] grant_idx,
  output logic                     grant_valid
);

  logic [PORT_ID_WIDTH-1:0] rr_ptr;
  logic [MAX_PORTS-1:0]     mask;
  int                       pick;

  always_comb begin
    mask                  = '0;
    mask[NUM_PORTS-1:0]   = req;
    pick                  = rr_next(mask, int'(rr_ptr), NUM_PORTS);
    grant                 = '0;
    grant_idx             = '0;
    grant_valid           = 1'b0;
    if (enable && pick >= 0) begin
      grant_valid      = 1'b1;
      grant_idx        = pick[PORT_ID_WIDTH-1:0];
      grant[grant_idx] = 1'b1;
    end
  end

  // Pointer starts at the last port so port 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= PORT_ID_WIDTH'(NUM_PORTS - 1);
    end else if (advance) begin
      rr_ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/icache_refill_arbiter.sv
// rtl/icache_refill_arbiter.sv - shared refill RAM for per-engine icaches with host load port
module icache_refill_arbiter
  import icache_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int LINE_ADDR_WIDTH = DEF_LINE_ADDR_WIDTH,
  parameter int LINE_WIDTH      = DEF_LINE_WIDTH,
  parameter int PORT_ID_WIDTH   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 req_valid,
  input  logic [NUM_PORTS*LINE_ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_PORTS-1:0]                 req_ready,
  output logic [LINE_WIDTH-1:0]                rdata,
  output logic [PORT_ID_WIDTH-1:0]             rdata_port,
  output logic                                 rdata_valid,
  input  logic                                 wr_valid,
  input  logic [LINE_ADDR_WIDTH-1:0]           wr_addr,
  input  logic [LINE_WIDTH-1:0]                wr_data,
  output logic                                 busy
);

  logic [LINE_WIDTH-1:0]      mem [0:(2**LINE_ADDR_WIDTH)-1];
  logic [NUM_PORTS-1:0]       grant;
  logic [PORT_ID_WIDTH-1:0]   grant_idx;
  logic                       grant_valid;
  logic [LINE_ADDR_WIDTH-1:0] sel_addr;

  // Host writes lock out refills so a read and write never share an edge.
  rr_arbiter #(
    .NUM_PORTS     (NUM_PORTS),
    .PORT_ID_WIDTH (PORT_ID_WIDTH)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req_valid),
    .enable      (!wr_valid && !rst),
    .advance     (grant_valid),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant;
  assign busy      = (|req_valid) | rdata_valid;

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) sel_addr = req_addr[i*LINE_ADDR_WIDTH +: LINE_ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_valid) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata       <= '0;
      rdata_port  <= '0;
      rdata_valid <= 1'b0;
    end else if (grant_valid) begin
      rdata       <= mem[sel_addr];
      rdata_port  <= grant_idx;
      rdata_valid <= 1'b1;
    end else begin
      rdata_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_icache_refill_arbiter.sv
// tb/tb_icache_refill_arbiter.sv - randomized and directed bench against a queue-free reference model
module tb_icache_refill_arbiter;

  localparam int NP = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [47:0] req_addr;
  logic [3:0]  req_ready;
  logic [63:0] rdata;
  logic [1:0]  rdata_port;
  logic        rdata_valid;
  logic        wr_valid;
  logic [11:0] wr_addr;
  logic [63:0] wr_data;
  logic        busy;

  icache_refill_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .rdata       (rdata),
    .rdata_port  (rdata_port),
    .rdata_valid (rdata_valid),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] mem_m [int];
  int          m_ptr;
  logic        m_valid;
  logic [63:0] m_data;
  int          m_port;
  int          last_grant;
  int          pool [7] = '{0, 1, 2, 3, 4, 5, 'hFFF};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [47:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {a3[11:0], a2[11:0], a1[11:0], a0[11:0]};
  endfunction

  task automatic cycle(input logic r, input logic [3:0] v, input logic [47:0] a,
                       input logic w, input logic [11:0] wa, input logic [63:0] wd);
    int g;
    logic [3:0] exp_rdy;
    logic [11:0] ga;
    @(negedge clk);
    rst = r; req_valid = v; req_addr = a; wr_valid = w; wr_addr = wa; wr_data = wd;
    #1;
    g = -1;
    if (!r && !w) begin
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (m_ptr + k) % NP;
        if (g < 0 && v[p]) g = p;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("busy", 64'(busy), 64'((|v) | m_valid));
    last_grant = g;
    @(posedge clk);
    if (w) mem_m[int'(wa)] = wd;
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_port = 0; m_ptr = NP - 1;
    end else if (g >= 0) begin
      ga = a[g*12 +: 12];
      m_valid = 1'b1; m_data = mem_m[int'(ga)]; m_port = g; m_ptr = g;
    end else begin
      m_valid = 1'b0;
    end
    #1;
    check("rdata_valid", 64'(rdata_valid), 64'(m_valid));
    check("rdata", rdata, m_data);
    if (m_valid) check("rdata_port", 64'(rdata_port), 64'(m_port));
  endtask

  task automatic idle_write(input int wa, input logic [63:0] wd);
    cycle(1'b0, 4'b0000, '0, 1'b1, wa[11:0], wd);
  endtask

  initial begin
    logic [47:0] a4;
    logic [3:0]  rv;
    logic        wv;
    int          wi;
    rst = 1'b1; req_valid = '0; req_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    m_ptr = NP - 1; m_valid = 1'b0; m_data = '0; m_port = 0; last_grant = -1;

    cycle(1'b1, 4'b0000, '0, 1'b0, '0, '0);
    cycle(1'b1, 4'b0000, '0, 1'b0, '0, '0);
    check("reset_rdata", rdata, 64'h0);

    for (int i = 1; i <= 4; i++) idle_write(i, {$urandom, $urandom});
    idle_write('hFFF, {$urandom, $urandom});
    idle_write('h000, 64'h1111_2222_3333_4444);
    idle_write('h005, 64'hDEAD_BEEF_0000_0001);

    cycle(1'b0, 4'b0001, pack(5, 0, 0, 0), 1'b0, '0, '0);
    check("prog_grant", 64'(last_grant), 64'd0);
    check("prog_rdata", rdata, 64'hDEAD_BEEF_0000_0001);

    cycle(1'b0, 4'b1000, pack(0, 0, 0, 3), 1'b0, '0, '0);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 4'b1111, pack(0, 1, 2, 3), 1'b0, '0, '0);
      check("fair_grant", 64'(last_grant), 64'(k % 4));
    end

    cycle(1'b0, 4'b0010, pack(0, 4, 0, 0), 1'b1, 12'h004, 64'hCAFE_F00D_1234_5678);
    check("wrprio_ready", 64'(req_ready), 64'h0);
    cycle(1'b0, 4'b0010, pack(0, 4, 0, 0), 1'b0, '0, '0);
    check("wrprio_grant", 64'(last_grant), 64'd1);
    check("wrprio_rdata", rdata, 64'hCAFE_F00D_1234_5678);

    cycle(1'b0, 4'b0011, pack(0, 5, 0, 0), 1'b0, '0, '0);
    check("skip_first", 64'(last_grant), 64'd0);
    cycle(1'b0, 4'b0011, pack(0, 5, 0, 0), 1'b0, '0, '0);
    check("skip_second", 64'(last_grant), 64'd1);

    cycle(1'b0, 4'b0100, pack(0, 0, 5, 0), 1'b0, '0, '0);
    cycle(1'b1, 4'b1111, pack(0, 1, 2, 3), 1'b0, '0, '0);
    check("rst_valid", 64'(rdata_valid), 64'h0);
    check("rst_rdata", rdata, 64'h0);
    cycle(1'b0, 4'b1111, pack(0, 1, 2, 3), 1'b0, '0, '0);
    check("post_rst_grant", 64'(last_grant), 64'd0);

    for (int k = 0; k < 5; k++) cycle(1'b0, 4'b0000, '0, 1'b0, '0, '0);
    check("idle_busy", 64'(busy), 64'h0);

    for (int n = 0; n < 400; n++) begin
      a4 = pack(pool[$urandom_range(6)], pool[$urandom_range(6)],
                pool[$urandom_range(6)], pool[$urandom_range(6)]);
      rv = 4'($urandom);
      wv = ($urandom_range(7) == 0);
      wi = pool[$urandom_range(6)];
      cycle(($urandom_range(49) == 0), rv, a4, wv, wi[11:0], {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
